nibble_serial_adder: RTL

Sequential wide-operand adder that reuses the existing 4-bit `adder` one nibble per clock. It sits directly in front of `adder`: it latches two NIBBLES×4-bit operands, feeds `adder` its `x`, `y` and `c_in` one nibble at a time (LSB first), and captures `out` and `c_out` back into a result shift register. It then reports the full sum, carry and signed overflow with a one-cycle `done` pulse.

---
 rtl/nibble_serial_adder.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/nibble_serial_adder.sv
// Wide-operand adder that drives an external combinational 4-bit adder one nibble per cycle, LSB first.
// Optional subtract support (sub port) is compiled in when NIBBLE_SUB_EN is defined.
module nibble_serial_adder #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [4*NIBBLES-1:0]   a,
   input  logic [4*NIBBLES-1:0]   b,
`ifdef NIBBLE_SUB_EN
   input  logic                   sub,
`endif
   output logic [3:0]             add_x,
   output logic [3:0]             add_y,
   output logic                   add_cin,
   input  logic [3:0]             add_out,
   input  logic                   add_cout,
   output logic                   busy,
   output logic                   done,
   output logic [4*NIBBLES-1:0]   sum,
   output logic                   carry,
   output logic                   overflow
);

   localparam int W  = 4 * NIBBLES;
   localparam int IW = $clog2(NIBBLES) + 1;
   localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    sa_q, sa_d, sb_q, sb_d, res_q, res_d, sum_q, sum_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            cry_q, cry_d, amsb_q, amsb_d, bmsb_q, bmsb_d;
   logic            carry_q, carry_d, ovf_q, ovf_d;
   logic            sub_req, sub_act;
   logic            accept;

   assign accept = (state_q == IDLE) && start;

`ifdef NIBBLE_SUB_EN
   logic sub_q, sub_d;
   assign sub_req = sub;
   assign sub_act = sub_q;
   assign sub_d   = accept ? sub : sub_q;
   always_ff @(posedge clk) begin
      if (reset) sub_q <= 1'b0;
      else       sub_q <= sub_d;
   end
`else
   assign sub_req = 1'b0;
   assign sub_act = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         cry_q   <= 1'b0;
         amsb_q  <= 1'b0;
         bmsb_q  <= 1'b0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         idx_q   <= idx_d;
         cry_q   <= cry_d;
         amsb_q  <= amsb_d;
         bmsb_q  <= bmsb_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      res_d   = res_q;
      sum_d   = sum_q;
      idx_d   = idx_q;
      cry_d   = cry_q;
      amsb_d  = amsb_q;
      bmsb_d  = bmsb_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      add_x   = 4'h0;
      add_y   = 4'h0;
      add_cin = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               sa_d    = a;
               sb_d    = b;
               res_d   = '0;
               cry_d   = sub_req;
               idx_d   = '0;
               amsb_d  = a[W-1];
               bmsb_d  = b[W-1] ^ sub_req;
               state_d = ADD;
            end
         end
         ADD: begin
            add_x   = sa_q[3:0];
            add_y   = sb_q[3:0] ^ {4{sub_act}};
            add_cin = cry_q;
            // Returned nibble enters at the top so the LSB nibble lands at bit 0 after NIBBLES shifts.
            res_d   = (res_q >> 4) | (W'(add_out) << (W - 4));
            sa_d    = sa_q >> 4;
            sb_d    = sb_q >> 4;
            cry_d   = add_cout;
            idx_d   = idx_q + 1'b1;
            if (idx_q == LAST) begin
               sum_d   = res_d;
               carry_d = add_cout;
               ovf_d   = (amsb_q == bmsb_q) && (add_out[3] != amsb_q);
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign busy     = (state_q != IDLE);
   assign done     = (state_q == DONE);
   assign sum      = sum_q;
   assign carry    = carry_q;
   assign overflow = ovf_q;

endmodule
